// File: rtl/pulse_gen.sv
// Phase-accumulator pulse generator driving an offset-binary DAC code.
// Runs continuously or for a triggered burst of whole periods; settings take effect only at period boundaries.
module pulse_gen #(
    parameter int ACC_W  = 20,
    parameter int FREQ_W = 16,
    parameter int PH_W   = 8,
    parameter int DAC_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              trig,
    input  logic [7:0]        burst_len,
    input  logic [FREQ_W-1:0] freq,
    input  logic [PH_W-1:0]   duty,
    input  logic [PH_W-1:0]   phase,
    input  logic [2:0]        amp,
    output logic [DAC_W-1:0]  DAC_in,
    output logic              sync,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [DAC_W-1:0] MID    = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0] MID_M1 = {1'b0, {(DAC_W-1){1'b1}}};

    state_t              state_r, state_next_s;
    logic [ACC_W-1:0]    acc_r;
    logic [FREQ_W-1:0]   freq_a_r;
    logic [PH_W-1:0]     duty_a_r;
    logic [PH_W-1:0]     phase_a_r;
    logic [2:0]          amp_a_r;
    logic [7:0]          len_a_r;
    logic [7:0]          cnt_r;
    logic [ACC_W:0]      sum_s;
    logic                wrap_s;
    logic                last_s;
    logic                load_s;
    logic [PH_W-1:0]     p_s;
    logic                level_s;
    logic [DAC_W-1:0]    code_s;

    // The high code tops out at MID + MID-1 so amp=0 reaches full scale without overflowing.
    function automatic logic [DAC_W-1:0] level_code(input logic lvl, input logic [2:0] sh);
        logic [DAC_W-1:0] c;
        if (lvl) begin
            c = MID + (MID_M1 >> sh);
        end else begin
            c = MID - (MID >> sh);
        end
        return c;
    endfunction

    // Accumulator sum, wrap detection and waveform level for the current acc value.
    always_comb begin
        sum_s   = {1'b0, acc_r} + (ACC_W+1)'(freq_a_r);
        wrap_s  = (state_r != IDLE) && sum_s[ACC_W];
        last_s  = (state_r == BURST) && (cnt_r == (len_a_r - 8'd1));
        p_s     = acc_r[ACC_W-1 -: PH_W] + phase_a_r;
        level_s = (p_s < duty_a_r);
        code_s  = level_code(level_s, amp_a_r);
    end

    // Next-state logic; disable always wins over trigger and burst completion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en && !mode) begin
                    state_next_s = RUN;
                end else if (en && mode && trig) begin
                    state_next_s = BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            BURST: begin
                if (!en) begin
                    state_next_s = IDLE;
                end else if (wrap_s && last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BURST;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Settings are captured on leaving IDLE and at each period boundary only.
    always_comb begin
        load_s = ((state_r == IDLE) && (state_next_s != IDLE)) || (wrap_s && en);
    end

    // State, accumulator, active settings, burst counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            acc_r     <= {ACC_W{1'b0}};
            freq_a_r  <= {FREQ_W{1'b0}};
            duty_a_r  <= {PH_W{1'b0}};
            phase_a_r <= {PH_W{1'b0}};
            amp_a_r   <= 3'd0;
            len_a_r   <= 8'd0;
            cnt_r     <= 8'd0;
            DAC_in    <= MID;
            sync      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) || (state_next_s == IDLE)) begin
                acc_r <= {ACC_W{1'b0}};
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
            end
            if (load_s) begin
                freq_a_r  <= freq;
                duty_a_r  <= duty;
                phase_a_r <= phase;
                amp_a_r   <= amp;
                len_a_r   <= burst_len;
            end else begin
                freq_a_r  <= freq_a_r;
                duty_a_r  <= duty_a_r;
                phase_a_r <= phase_a_r;
                amp_a_r   <= amp_a_r;
                len_a_r   <= len_a_r;
            end
            if ((state_r != BURST) || (state_next_s != BURST)) begin
                cnt_r <= 8'd0;
            end else if (wrap_s) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == IDLE) || (state_next_s == IDLE)) begin
                DAC_in <= MID;
            end else begin
                DAC_in <= code_s;
            end
            sync <= wrap_s && en;
            busy <= (state_next_s != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Randomised and directed bench for pulse_gen: a period-level reference model queues the expected
// outputs per cycle and an independent monitor compares them against the DUT.
module tb_pulse_gen;

    localparam int MID  = 8192;
    localparam int FULL = 1 << 20;

    logic        clk = 1'b0;
    logic        rst, en, mode, trig;
    logic [7:0]  burst_len;
    logic [15:0] freq;
    logic [7:0]  duty, phase;
    logic [2:0]  amp;
    logic [13:0] DAC_in;
    logic        sync, busy;

    pulse_gen dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
        .burst_len(burst_len), .freq(freq), .duty(duty), .phase(phase), .amp(amp),
        .DAC_in(DAC_in), .sync(sync), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int dac;
        bit sy;
        bit bz;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sync_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: running flag, position within the period as an integer, periods completed.
    int m_on = 0, m_burst = 0, m_acc = 0, m_per = 0;
    int m_f = 0, m_d = 0, m_ph = 0, m_amp = 0, m_len = 0;

    function automatic int expected_code(int a);
        int p;
        p = ((a / 4096) + m_ph) % 256;
        if (p < m_d) return MID + (MID - 1) / (1 << m_amp);
        return MID - MID / (1 << m_amp);
    endfunction

    task automatic latch_settings();
        m_f = freq; m_d = duty; m_ph = phase; m_amp = amp; m_len = burst_len;
    endtask

    task automatic model_step();
        int   dac, sum, target;
        bit   s;
        exp_t e;
        s   = 1'b0;
        dac = MID;
        if (rst) begin
            m_on = 0; m_acc = 0; m_per = 0;
            m_f = 0; m_d = 0; m_ph = 0; m_amp = 0; m_len = 0;
        end else if (m_on == 0) begin
            if (en && (!mode || trig)) begin
                m_on = 1; m_burst = mode; m_acc = 0; m_per = 0;
                latch_settings();
            end
        end else if (!en) begin
            m_on = 0; m_acc = 0;
        end else begin
            dac = expected_code(m_acc);
            sum = m_acc + m_f;
            if (sum >= FULL) begin
                sum = sum - FULL;
                s = 1'b1;
                target = (m_len == 0) ? 256 : m_len;
                if (m_burst != 0) begin
                    m_per = m_per + 1;
                    if (m_per == target) begin
                        m_on = 0; dac = MID; sum = 0;
                    end
                end
                latch_settings();
            end
            m_acc = sum;
        end
        e.cyc = cyc + 1; e.dac = dac; e.sy = s; e.bz = (m_on != 0);
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every queued expectation once the DUT has produced that cycle's outputs.
    always @(negedge clk) begin
        exp_t e;
        if (sync === 1'b1) sync_seen = sync_seen + 1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                checks++; errors++;
                $display("FAIL stale_expectation cyc=%0d got_cycle=%0d", e.cyc, cyc);
            end else begin
                checks++;
                if (DAC_in !== 14'(e.dac)) begin
                    errors++;
                    $display("FAIL dac cyc=%0d actual=%0d expected=%0d", cyc, DAC_in, e.dac);
                end
                checks++;
                if (sync !== e.sy) begin
                    errors++;
                    $display("FAIL sync cyc=%0d actual=%b expected=%b", cyc, sync, e.sy);
                end
                checks++;
                if (busy !== e.bz) begin
                    errors++;
                    $display("FAIL busy cyc=%0d actual=%b expected=%b", cyc, busy, e.bz);
                end
            end
        end
    end

    initial begin
        int s0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; trig = 1'b0;
        burst_len = 8'd0; freq = 16'd0; duty = 8'd0; phase = 8'd0; amp = 3'd0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Continuous mode, then amplitude, phase and duty variations.
        en = 1'b1; freq = 16'd4096; duty = 8'd128;
        tick(600);
        amp = 3'd1;  tick(300);
        amp = 3'd7;  tick(300);
        amp = 3'd0; phase = 8'd64; tick(300);
        duty = 8'd0; tick(300);
        duty = 8'd255; phase = 8'd0; tick(300);
        duty = 8'd128; tick(100);
        freq = 16'd8192; tick(400);
        mode = 1'b1; tick(50);

        // Burst of 3 periods with an ignored retrigger.
        en = 1'b0; tick(2);
        en = 1'b1; freq = 16'd4096; burst_len = 8'd3;
        tick(5);
        s0 = sync_seen;
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(100);
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(800);
        checks++;
        if (sync_seen - s0 != 3) begin
            errors++;
            $display("FAIL burst3_sync_count actual=%0d expected=3", sync_seen - s0);
        end

        // burst_len=0 means 256 periods.
        burst_len = 8'd0; freq = 16'hFFFF;
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(4200);

        // Reset and disable mid-burst, then restart from phase 0.
        freq = 16'd4096; burst_len = 8'd5;
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(300);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(3);
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(300);
        en = 1'b0; trig = 1'b1; tick(1); trig = 1'b0;
        tick(3);
        en = 1'b1; trig = 1'b1; tick(1); trig = 1'b0;
        tick(200);

        // Zero frequency: static level, burst never ends until disabled.
        en = 1'b0; tick(2);
        en = 1'b1; freq = 16'd0; phase = 8'd200; duty = 8'd100;
        trig = 1'b1; tick(1); trig = 1'b0;
        tick(100);
        en = 1'b0; tick(3);

        // Randomised operation.
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                freq      = 16'($urandom_range(0, 65535));
                duty      = 8'($urandom_range(0, 255));
                phase     = 8'($urandom_range(0, 255));
                amp       = 3'($urandom_range(0, 7));
                burst_len = 8'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            trig = ($urandom_range(0, 49) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0; trig = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() > 1) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected<=1", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
